// File: rtl/div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the EX-stage divide controller: operand/result
// widths, the two divide opcodes, the controller FSM state encoding and a
// small opcode decode helper.
// Optional feature macro used by the controller: DIV_ZERO_EXC_EN.
// ---------------------------------------------------------------------------
package div_ctrl_pkg;

    localparam int DATA_W    = 32;
    localparam int OP_W      = 8;
    localparam int DIV_RES_W = 64;   // {remainder, quotient}

    localparam logic [OP_W-1:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [OP_W-1:0] EXE_DIVU_OP = 8'b00011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_ctrl_if
// Bundle between the divide controller and the iterative divider that sits
// beside it in the EX stage.
//   div_start_o   : controller -> divider, high while a divide is wanted
//   div_annul_o   : controller -> divider, abandon the current divide
//   div_signed_o  : controller -> divider, 1 = signed (DIV), 0 = DIVU
//   div_opdata1_o : controller -> divider, dividend
//   div_opdata2_o : controller -> divider, divisor
//   div_result_i  : divider -> controller, {remainder, quotient}
//   div_ready_i   : divider -> controller, result valid this cycle
//   dbg_state     : controller FSM state, observation only
// Handshake: the divider samples operands while div_start_o is high; the
// controller accepts div_result_i on any cycle div_ready_i is high while it
// is waiting, and ignores div_ready_i otherwise. There is no backpressure.
// ---------------------------------------------------------------------------
interface div_ctrl_if;

    logic                                 div_start_o;
    logic                                 div_annul_o;
    logic                                 div_signed_o;
    logic [div_ctrl_pkg::DATA_W-1:0]      div_opdata1_o;
    logic [div_ctrl_pkg::DATA_W-1:0]      div_opdata2_o;
    logic [div_ctrl_pkg::DIV_RES_W-1:0]   div_result_i;
    logic                                 div_ready_i;
    div_ctrl_pkg::div_state_e             dbg_state;

    modport master (
        output div_start_o, div_annul_o, div_signed_o,
               div_opdata1_o, div_opdata2_o, dbg_state,
        input  div_result_i, div_ready_i
    );

    modport slave (
        input  div_start_o, div_annul_o, div_signed_o,
               div_opdata1_o, div_opdata2_o,
        output div_result_i, div_ready_i
    );

endinterface

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
// EX-stage controller for a multi-cycle divider. Issues DIV/DIVU to the
// divider, stalls the pipeline while it runs, and writes the result back to
// HI/LO once the pipeline is free to accept it.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst        : asynchronous active-low reset
//   aluop_i    : EX-stage opcode (DIV / DIVU start a divide)
//   reg1_i     : dividend
//   reg2_i     : divisor
//   flush_i    : pipeline flush, abandons any divide in progress
//   stall_i    : downstream stall holding EX
//   stallreq_o : stall request to pipeline control
//   hilo_we_o  : one-cycle HI/LO write enable
//   hi_o/lo_o  : remainder / quotient for the write-back
//   div_zero_o : divide-by-zero pulse (only with DIV_ZERO_EXC_EN)
//   div_bus    : divider bundle (master side)
//
// Configuration
//   DIV_ZERO_EXC_EN : when defined, a zero divisor is recorded at issue and
//                     reported by a div_zero_o pulse instead of a write-back.
//                     When undefined, div_zero_o is 0 and the divider's
//                     result is written back as usual.
// ---------------------------------------------------------------------------
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OP_W-1:0]      aluop_i,
    input  logic [DATA_W-1:0]    reg1_i,
    input  logic [DATA_W-1:0]    reg2_i,
    input  logic                 flush_i,
    input  logic                 stall_i,
    output logic                 stallreq_o,
    output logic                 hilo_we_o,
    output logic [DATA_W-1:0]    hi_o,
    output logic [DATA_W-1:0]    lo_o,
    output logic                 div_zero_o,
    div_ctrl_if.master           div_bus
);

    div_state_e          r_state;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic                r_signed;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_issue;
    logic                w_busy;
    logic                w_done;
    logic                w_wb;
    logic                w_op_signed;

    // Outputs are decoded from inputs in the issue cycle, so they are also
    // qualified with rst to keep everything at zero while reset is held.
    assign w_op_signed = (aluop_i == EXE_DIV_OP);
    assign w_issue     = rst && !flush_i && (r_state == ST_IDLE) && is_div_op(aluop_i);
    assign w_busy      = (r_state != ST_IDLE);
    assign w_done      = (r_state == ST_DONE);
    // The single exit cycle of DONE; flush takes priority over write-back.
    assign w_wb        = w_done && !stall_i && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_op1    <= '0;
            r_op2    <= '0;
            r_signed <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (flush_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (is_div_op(aluop_i)) begin
                        r_op1    <= reg1_i;
                        r_op2    <= reg2_i;
                        r_signed <= w_op_signed;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (div_bus.div_ready_i) begin
                        r_hi    <= div_bus.div_result_i[DIV_RES_W-1:DATA_W];
                        r_lo    <= div_bus.div_result_i[DATA_W-1:0];
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!stall_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DIV_ZERO_EXC_EN
    logic r_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_zero <= 1'b0;
        end else if (w_issue) begin
            r_zero <= (reg2_i == '0);
        end
    end

    assign hilo_we_o  = w_wb && !r_zero;
    assign div_zero_o = w_wb && r_zero;
`else
    assign hilo_we_o  = w_wb;
    assign div_zero_o = 1'b0;
`endif

    // Divider side: pass the EX operands straight through in the issue
    // cycle so the divider samples them immediately, then hold the latched
    // copies until DONE is left.
    assign div_bus.div_start_o   = rst && !flush_i && (w_issue || (r_state == ST_WAIT));
    assign div_bus.div_annul_o   = rst && flush_i;
    assign div_bus.div_signed_o  = w_issue ? w_op_signed : (w_busy && r_signed);
    assign div_bus.div_opdata1_o = w_issue ? reg1_i : (w_busy ? r_op1 : '0);
    assign div_bus.div_opdata2_o = w_issue ? reg2_i : (w_busy ? r_op2 : '0);
    assign div_bus.dbg_state     = r_state;

    assign stallreq_o = div_bus.div_start_o;

    // HI/LO are only presented while DONE; the outputs idle at zero.
    assign hi_o = w_done ? r_hi : '0;
    assign lo_o = w_done ? r_lo : '0;

endmodule

// File: tb/tb_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ctrl
// Self-checking bench for div_ctrl. A behavioural divider answers the
// controller with a programmable latency; every issued divide pushes its
// expected write-back onto a queue which a separate monitor pops whenever
// the controller writes HI/LO or reports divide-by-zero.
// ---------------------------------------------------------------------------
module tb_div_ctrl;
    import div_ctrl_pkg::*;

`ifdef DIV_ZERO_EXC_EN
    localparam bit ZERO_EXC = 1'b1;
`else
    localparam bit ZERO_EXC = 1'b0;
`endif

    localparam logic [7:0] NOP_OP = 8'h00;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        flush_i;
    logic        stall_i;
    logic        stallreq_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_zero_o;

    div_ctrl_if bus();

    div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .flush_i    (flush_i),
        .stall_i    (stall_i),
        .stallreq_o (stallreq_o),
        .hilo_we_o  (hilo_we_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_zero_o (div_zero_o),
        .div_bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [64:0] exp_q[$];   // {div_zero, hi, lo}
    int n_cmp  = 0;
    int n_err  = 0;
    int wb_cnt = 0;
    int dv_lat = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: quotient truncates toward zero, remainder takes
    // the dividend's sign; a zero divisor yields 0/0.
    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [64:0] expect_wb(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic z;
        z = ZERO_EXC && (b == 32'd0);
        return {z, div_model(a, b, op == EXE_DIV_OP)};
    endfunction

    // ---------------- behavioural divider ----------------
    initial begin
        logic        dv_busy;
        int          dv_cnt;
        logic [63:0] dv_res;
        dv_busy = 1'b0;
        dv_cnt  = 0;
        dv_res  = '0;
        bus.div_ready_i  = 1'b0;
        bus.div_result_i = '0;
        forever begin
            @(negedge clk);
            if (!rst || bus.div_annul_o) begin
                dv_busy = 1'b0;
                bus.div_ready_i = 1'b0;
            end else if (bus.div_ready_i) begin
                bus.div_ready_i = 1'b0;
            end else if (dv_busy) begin
                if (dv_cnt == 0) begin
                    bus.div_result_i = dv_res;
                    bus.div_ready_i  = 1'b1;
                    dv_busy = 1'b0;
                end else begin
                    dv_cnt--;
                end
            end else if (bus.div_start_o) begin
                dv_res  = div_model(bus.div_opdata1_o, bus.div_opdata2_o, bus.div_signed_o);
                dv_cnt  = dv_lat;
                dv_busy = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [64:0] exp;
        forever begin
            @(negedge clk);
            if (hilo_we_o || div_zero_o) begin
                wb_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_writeback: got %h, expected none (t=%0t)",
                             {div_zero_o, hi_o, lo_o}, $time);
                end else begin
                    exp = exp_q.pop_front();
                    check("writeback", {div_zero_o, hi_o, lo_o}, exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {58'd0, bus.div_start_o, bus.div_annul_o, bus.div_signed_o,
                               stallreq_o, hilo_we_o, div_zero_o, 1'b0}, 65'd0);
        check({name, "_ops"}, {1'b0, bus.div_opdata1_o, bus.div_opdata2_o}, 65'd0);
        check({name, "_hilo"}, {1'b0, hi_o, lo_o}, 65'd0);
    endtask

    task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int stall_n);
        int   ev0;
        int   cyc;
        logic sgn;
        logic hold_ok;
        ev0     = wb_cnt;
        sgn     = (op == EXE_DIV_OP);
        hold_ok = 1'b1;
        cyc     = 0;
        dv_lat  = lat;
        @(posedge clk); #1;
        aluop_i = op;
        reg1_i  = a;
        reg2_i  = b;
        exp_q.push_back(expect_wb(op, a, b));
        @(negedge clk);
        check("issue_start",    {64'd0, bus.div_start_o}, 65'd1);
        check("issue_stallreq", {64'd0, stallreq_o}, 65'd1);
        check("issue_ops",      {1'b0, bus.div_opdata1_o, bus.div_opdata2_o}, {1'b0, a, b});
        check("issue_signed",   {64'd0, bus.div_signed_o}, {64'd0, sgn});
        @(posedge clk); #1;
        aluop_i = NOP_OP;
        reg1_i  = $urandom;
        reg2_i  = $urandom;
        stall_i = (stall_n > 0);
        // WAIT: stall request stays up until the divider answers.
        forever begin
            @(negedge clk);
            if (bus.div_opdata1_o !== a || bus.div_opdata2_o !== b || bus.div_signed_o !== sgn)
                hold_ok = 1'b0;
            if (!stallreq_o) break;
            cyc++;
            if (cyc > 200) break;
            @(posedge clk); #1;
        end
        check("done_reached", {64'd0, cyc <= 200}, 65'd1);
        if (cyc > 200) begin
            stall_i = 1'b0;
            return;
        end
        check("done_start", {64'd0, bus.div_start_o}, 65'd0);
        for (int k = 0; k < stall_n; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                @(negedge clk);
            end
            check("done_stalled_we", {63'd0, hilo_we_o, div_zero_o}, 65'd0);
            if (bus.div_opdata1_o !== a || bus.div_opdata2_o !== b || bus.div_signed_o !== sgn)
                hold_ok = 1'b0;
        end
        if (stall_n > 0) begin
            @(posedge clk); #1;
            stall_i = 1'b0;
            @(negedge clk);
        end
        check("done_pulse", {64'd0, hilo_we_o | div_zero_o}, 65'd1);
        check("operand_hold", {64'd0, hold_ok}, 65'd1);
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("single_event", 65'(wb_cnt - ev0), 65'd1);
        check_all_zero("back_idle");
    endtask

    function automatic logic [31:0] rand_divisor();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 9));
            1:       return 32'($urandom_range(1, 1000));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int ev0;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst     = 1'b0;
        aluop_i = NOP_OP;
        reg1_i  = '0;
        reg2_i  = '0;
        flush_i = 1'b0;
        stall_i = 1'b0;

        // Reset holds everything at zero even with a divide on the opcode bus.
        repeat (2) @(posedge clk);
        #1;
        aluop_i = EXE_DIV_OP;
        reg1_i  = 32'd7;
        reg2_i  = 32'd2;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst     = 1'b1;
        aluop_i = NOP_OP;

        // Non-divide opcodes leave the outputs idle.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            op = 8'($urandom_range(0, 255));
            if (is_div_op(op)) op = NOP_OP;
            aluop_i = op;
            reg1_i  = $urandom;
            reg2_i  = $urandom;
            @(negedge clk);
            check_all_zero("idle_nondiv");
        end
        @(posedge clk); #1;
        aluop_i = NOP_OP;

        // Directed cases.
        do_div(EXE_DIVU_OP, 32'd7, 32'd2, 3, 0);
        do_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'h0000_0002, 2, 1);
        do_div(EXE_DIVU_OP, $urandom, 32'd13, 1, 3);
        do_div(EXE_DIVU_OP, 32'd5, 32'd0, 2, 0);
        do_div(EXE_DIV_OP, 32'd100, 32'd0, 0, 2);

        // Flush ten cycles into a long divide.
        ev0    = wb_cnt;
        dv_lat = 40;
        @(posedge clk); #1;
        aluop_i = EXE_DIV_OP;
        reg1_i  = $urandom;
        reg2_i  = 32'd5;
        @(posedge clk); #1;
        aluop_i = NOP_OP;
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_annul", {64'd0, bus.div_annul_o}, 65'd1);
        check("flush_start", {64'd0, bus.div_start_o}, 65'd0);
        check("flush_we",    {64'd0, hilo_we_o}, 65'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        check_all_zero("after_flush");
        repeat (50) @(posedge clk);
        #1;
        check("flush_no_wb", 65'(wb_cnt - ev0), 65'd0);
        do_div(EXE_DIVU_OP, 32'd9, 32'd3, 4, 0);

        // A divide arriving together with a flush must not issue.
        @(posedge clk); #1;
        aluop_i = EXE_DIVU_OP;
        reg1_i  = 32'd8;
        reg2_i  = 32'd2;
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_issue_start", {63'd0, bus.div_start_o, stallreq_o}, 65'd0);
        check("flush_issue_annul", {64'd0, bus.div_annul_o}, 65'd1);
        @(posedge clk); #1;
        aluop_i = NOP_OP;
        flush_i = 1'b0;
        @(negedge clk);
        check_all_zero("flush_issue_idle");

        // Reset in the middle of WAIT abandons the divide.
        ev0    = wb_cnt;
        dv_lat = 30;
        @(posedge clk); #1;
        aluop_i = EXE_DIVU_OP;
        reg1_i  = 32'd100;
        reg2_i  = 32'd7;
        @(posedge clk); #1;
        aluop_i = NOP_OP;
        repeat (3) @(posedge clk);
        #3;
        rst     = 1'b0;
        aluop_i = EXE_DIV_OP;
        flush_i = 1'b1;
        #1;
        check_all_zero("rst_midwait");
        @(negedge clk);
        check_all_zero("rst_held");
        @(posedge clk); #1;
        rst     = 1'b1;
        aluop_i = NOP_OP;
        flush_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("rst_no_wb", 65'(wb_cnt - ev0), 65'd0);

        // Randomised divides.
        for (int i = 0; i < 12; i++) begin
            op = $urandom_range(0, 1) ? EXE_DIV_OP : EXE_DIVU_OP;
            a  = $urandom;
            b  = rand_divisor();
            if (op == EXE_DIV_OP && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            do_div(op, a, b, $urandom_range(0, 6), $urandom_range(0, 2));
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 65'(exp_q.size()), 65'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard bound on the whole run.
    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, expected completion before %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

endmodule
